// File: rtl/rotate_left_seq.sv
// Sequential left-rotate unit: rotates a WIDTH-bit word left one bit per clock over valid/ready handshakes.
// Optional build macro ROTL_LSL_EN adds a mode port selecting logical shift left (zero fill) instead of rotate.
module rotate_left_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
`ifdef ROTL_LSL_EN
   input  logic             mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data;
   logic [AMT_W-1:0] cnt;
   logic             accept;
   logic             lsl;

   assign accept = in_valid && (state == IDLE);

`ifdef ROTL_LSL_EN
   // Operation kind is captured with the operands so later mode changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lsl <= 1'b0;
      end else if (accept) begin
         lsl <= mode;
      end
   end
`else
   assign lsl = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = (amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == AMT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode only the state and data registers.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      y         = data;
      unique case (state)
         IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load on accept, then one rotate (or zero-fill shift) per SHIFT cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
         cnt  <= '0;
      end else if (accept) begin
         data <= a;
         cnt  <= amt;
      end else if (state == SHIFT) begin
         data <= {data[WIDTH-2:0], (lsl ? 1'b0 : data[WIDTH-1])};
         cnt  <= cnt - AMT_W'(1);
      end
   end

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: directed steps plus randomized inverse checks against a reference model.
// Define ROTL_LSL_EN to also exercise the logical-shift mode.
module tb_rotate_left_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned AMT_W = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [AMT_W-1:0] amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             busy;
`ifdef ROTL_LSL_EN
   logic             mode;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rotate_left_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .amt       (amt),
`ifdef ROTL_LSL_EN
      .mode      (mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   // Reference: rotl(x, n) = low WIDTH bits of {x, x} >> (WIDTH - n).
   function automatic logic [WIDTH-1:0] ref_rotl(input logic [WIDTH-1:0] x, input int n);
      logic [2*WIDTH-1:0] d;
      d = {x, x};
      return WIDTH'(d >> (WIDTH - n));
   endfunction

   function automatic logic [WIDTH-1:0] ref_rotr(input logic [WIDTH-1:0] x, input int n);
      logic [2*WIDTH-1:0] d;
      d = {x, x};
      return WIDTH'(d >> n);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction; bp > 0 holds out_ready low for bp cycles after out_valid rises.
   task automatic do_op(input string tag, input logic [WIDTH-1:0] av, input int am,
                        input logic md, input int bp, input logic [WIDTH-1:0] exp);
      int edges;
      int waits;
      logic [WIDTH-1:0] y_hold;
      waits = 0;
      while (in_ready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      a         = av;
      amt       = AMT_W'(am);
`ifdef ROTL_LSL_EN
      mode      = md;
`endif
      out_ready = (bp == 0);
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~av;
      amt      = AMT_W'(am + 3);
`ifdef ROTL_LSL_EN
      mode     = ~md;
`endif
      while (out_valid !== 1'b1 && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({tag, "_lat"}, 32'(edges), 32'(am + 1));
      check({tag, "_y"}, 32'(y), 32'(exp));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (bp > 0) begin
         y_hold = y;
         for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            a        = 8'hFF;
            amt      = 3'd5;
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_y"}, 32'(y), 32'(y_hold));
            check({tag, "_bp_inready"}, 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] r;
      int edges;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      amt       = '0;
      out_ready = 1'b0;
`ifdef ROTL_LSL_EN
      mode      = 1'b0;
`endif
      #12;
      check("rst_y", 32'(y), 32'h00);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      do_op("basic", 8'hB4, 3, 1'b0, 0, 8'hA5);
      do_op("amt_max", 8'h81, 7, 1'b0, 0, 8'hC0);
      do_op("amt_zero", 8'h5A, 0, 1'b0, 0, 8'h5A);
      do_op("backpressure", 8'h3C, 2, 1'b0, 5, ref_rotl(8'h3C, 2));

      // Reset during SHIFT of amt = 6.
      in_valid = 1'b1;
      a        = 8'h77;
      amt      = 3'd6;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_busy_pre", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_y", 32'(y), 32'h00);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      edges = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid === 1'b1) edges++;
      end
      check("midrst_no_valid", 32'(edges), 32'd0);
      do_op("post_rst", 8'h01, 1, 1'b0, 0, 8'h02);

      // Inverse: rotating a right-rotated word left by the same amount recovers it.
      for (int i = 0; i < 256; i++) begin
         r = WIDTH'($urandom);
         for (int s = 0; s < int'(WIDTH); s++) begin
            do_op("inverse", ref_rotr(r, s), s, 1'b0, 0, r);
         end
      end

      for (int i = 0; i < 16; i++) begin
         r = WIDTH'($urandom);
         edges = int'($urandom_range(0, WIDTH - 1));
         do_op("rand_rotl", r, edges, 1'b0, int'($urandom_range(0, 2)), ref_rotl(r, edges));
      end

`ifdef ROTL_LSL_EN
      do_op("lsl_basic", 8'hB4, 3, 1'b1, 0, 8'hA0);
      for (int i = 0; i < 16; i++) begin
         r = WIDTH'($urandom);
         edges = int'($urandom_range(0, WIDTH - 1));
         do_op("rand_lsl", r, edges, 1'b1, 0, WIDTH'(int'(r) * (1 << edges)));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
